// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the riscv memory responder.
//   - access-size encodings carried on the `by` field
//   - responder FSM state type
//   - wait-state counter width (holds WAIT_CYCLES up to 15)
package riscv_mem_pkg;

  localparam logic [1:0] BY_B   = 2'b00;
  localparam logic [1:0] BY_H   = 2'b01;
  localparam logic [1:0] BY_W   = 2'b10;
  localparam logic [1:0] BY_RSV = 2'b11;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } resp_state_e;

endpackage

// File: rtl/riscv_mem_responder_if.sv
// Request/response bundle between the core's memory port and the responder.
//   master : requester side (drives req, RE, WE, by, addr, data_in)
//   slave  : responder side (drives data_out, ack, busy, fault)
interface riscv_mem_responder_if;

  logic        req;
  logic        RE;
  logic        WE;
  logic [1:0]  by;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ack;
  logic        busy;
  logic        fault;

  modport master (
    output req, RE, WE, by, addr, data_in,
    input  data_out, ack, busy, fault
  );

  modport slave (
    input  req, RE, WE, by, addr, data_in,
    output data_out, ack, busy, fault
  );

endinterface

// File: rtl/riscv_mem_lane.sv
// Combinational byte/half/word lane steering for the memory responder.
//   word_i  : current contents of the addressed array word
//   by_i    : access size (BY_B / BY_H / BY_W; reserved leaves word untouched)
//   off_i   : byte offset addr[1:0]
//   wdata_i : right-aligned write data
//   wword_o : word with the selected lanes replaced by write data
//   rdata_o : selected lanes, right-aligned and zero-extended
module riscv_mem_lane
  import riscv_mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  by_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] wword_o,
  output logic [31:0] rdata_o
);

  always_comb begin
    wword_o = word_i;
    rdata_o = '0;
    case (by_i)
      BY_B: begin
        wword_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
        rdata_o[7:0]                  = word_i[{off_i, 3'b000} +: 8];
      end
      // Half lanes use only addr[1]; addr[0] is a misalignment concern
      // handled (or ignored) by the caller.
      BY_H: begin
        wword_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
        rdata_o[15:0]                      = word_i[{off_i[1], 4'b0000} +: 16];
      end
      BY_W: begin
        wword_o = wdata_i;
        rdata_o = word_i;
      end
      default: begin
        wword_o = word_i;
        rdata_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/riscv_mem_responder.sv
// Slow memory model for the core's load/store/fetch port. Accepts a read or
// write request, inserts WAIT_CYCLES wait states, then pulses ack for one
// cycle with right-aligned read data and a fault flag.
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : riscv_mem_responder_if.slave (req/RE/WE/by/addr/data_in in,
//              data_out/ack/busy/fault out)
// Parameters: ADDR_W (byte-address bits decoded), WAIT_CYCLES (0..15).
// Optional macro RISCV_MEM_RESP_ALIGN_CHK_EN: misaligned half/word accesses
// raise fault; without it the low address bits are silently ignored.
module riscv_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  riscv_mem_responder_if.slave  bus
);

  localparam int              WORDS   = 2 ** (ADDR_W - 2);
  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

  resp_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      dout_q;

  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [1:0]       by_q;
  logic             re_q;
  logic             we_q;

  logic [31:0]      mem_q [WORDS];

  logic             accept;
  logic             flt;
  logic [31:0]      word_rd;
  logic [31:0]      wword;
  logic [31:0]      rdata;
  logic [31:0]      rd_val;

  assign accept  = (state_q == IDLE) && bus.req && (bus.RE || bus.WE);
  assign word_rd = mem_q[addr_q[ADDR_W-1:2]];

  // Fault is evaluated on the latched request, so inputs may change freely
  // once the request is accepted.
  always_comb begin
    flt = (by_q == BY_RSV) || (re_q && we_q) || (|addr_q[31:ADDR_W]);
`ifdef RISCV_MEM_RESP_ALIGN_CHK_EN
    if ((by_q == BY_H) && addr_q[0])
      flt = 1'b1;
    if ((by_q == BY_W) && (addr_q[1:0] != 2'b00))
      flt = 1'b1;
`endif
  end

  riscv_mem_lane u_lane (
    .word_i  (word_rd),
    .by_i    (by_q),
    .off_i   (addr_q[1:0]),
    .wdata_i (wdata_q),
    .wword_o (wword),
    .rdata_o (rdata)
  );

  // Faults force zero; a plain write leaves the previous read value in place.
  assign rd_val = flt ? 32'h0 : (re_q ? rdata : dout_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = WAIT_LD;
          state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1))
          state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == RESP)
        dout_q <= rd_val;
    end
  end

  // Request capture; contents only matter once a request has been accepted.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= bus.addr;
      wdata_q <= bus.data_in;
      by_q    <= bus.by;
      re_q    <= bus.RE;
      we_q    <= bus.WE;
    end
  end

  // Write commits on the edge leaving RESP. A reset during WAIT/RESP
  // forces IDLE asynchronously, so an aborted write never reaches here.
  always_ff @(posedge clk) begin
    if ((state_q == RESP) && we_q && !flt)
      mem_q[addr_q[ADDR_W-1:2]] <= wword;
  end

  assign bus.ack      = (state_q == RESP);
  assign bus.busy     = (state_q != IDLE);
  assign bus.fault    = (state_q == RESP) && flt;
  assign bus.data_out = (state_q == RESP) ? rd_val : dout_q;

endmodule

// File: tb/tb_riscv_mem_responder.sv
// Bench for riscv_mem_responder: a WAIT_CYCLES=2 instance for functional
// scenarios and a WAIT_CYCLES=0 instance for the zero-wait / held-req case.
// Honors RISCV_MEM_RESP_ALIGN_CHK_EN when computing misalignment expectations.
module tb_riscv_mem_responder;
  import riscv_mem_pkg::*;

`ifdef RISCV_MEM_RESP_ALIGN_CHK_EN
  localparam bit ALN = 1'b1;
`else
  localparam bit ALN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic        fault;
    logic        chk;
  } exp_t;

  typedef struct packed {
    logic        re;
    logic        we;
    logic [1:0]  by;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] xd;
    logic        xf;
    logic        xchk;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  riscv_mem_responder_if bus ();
  riscv_mem_responder_if bus0 ();

  riscv_mem_responder #(.ADDR_W(12), .WAIT_CYCLES(2)) dut (
    .clk (clk), .reset_n (reset_n), .bus (bus)
  );
  riscv_mem_responder #(.ADDR_W(12), .WAIT_CYCLES(0)) dut0 (
    .clk (clk), .reset_n (reset_n), .bus (bus0)
  );

  int n_chk  = 0;
  int n_fail = 0;
  exp_t sb_q[$];
  logic [31:0] ref_mem [int];

  // Reference model for the random phase.
  function automatic exp_t model(logic re, logic we, logic [1:0] by,
                                 logic [31:0] a, logic [31:0] wd);
    exp_t e;
    logic [31:0] w;
    int idx;
    int k;
    e.fault = (by == 2'b11) || (re && we) || (a[31:12] != 20'h0);
    if (ALN && (((by == 2'b01) && a[0]) || ((by == 2'b10) && (a[1:0] != 2'b00))))
      e.fault = 1'b1;
    e.data = 32'h0;
    e.chk  = re || e.fault;
    if (e.fault) return e;
    idx = int'(a[11:2]);
    w = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
    if (by == 2'b00) begin
      k = int'(a[1:0]);
      if (re) e.data = (w >> (8 * k)) & 32'hFF;
      w = (w & ~(32'hFF << (8 * k))) | ((wd & 32'hFF) << (8 * k));
    end else if (by == 2'b01) begin
      k = a[1] ? 1 : 0;
      if (re) e.data = (w >> (16 * k)) & 32'hFFFF;
      w = (w & ~(32'hFFFF << (16 * k))) | ((wd & 32'hFFFF) << (16 * k));
    end else begin
      if (re) e.data = w;
      w = wd;
    end
    if (we) ref_mem[idx] = w;
    return e;
  endfunction

  // Drives one request on the WAIT_CYCLES=2 instance and collects its response.
  task automatic run_txn(input logic re, input logic we, input logic [1:0] by,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output logic [31:0] d, output logic f,
                         output bit to, output bit perr);
    @(negedge clk);
    bus.req = 1'b1; bus.RE = re; bus.WE = we; bus.by = by;
    bus.addr = a; bus.data_in = wd;
    lat = 0; to = 1'b0; perr = 1'b0; d = '0; f = 1'b0;
    @(posedge clk); #1;
    lat = 1;
    bus.req = 1'b0;
    bus.RE = 1'($urandom_range(0, 1));
    bus.WE = 1'($urandom_range(0, 1));
    bus.by = 2'($urandom_range(0, 3));
    bus.addr = $urandom;
    bus.data_in = $urandom;
    while (!bus.ack && lat < 40) begin
      if (!bus.busy) perr = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.ack) to = 1'b1;
    d = bus.data_out;
    f = bus.fault;
    @(posedge clk); #1;
    if (bus.ack || bus.busy || (bus.data_out !== d)) perr = 1'b1;
  endtask

  task automatic test_reset();
    bus.req = 0; bus.RE = 0; bus.WE = 0; bus.by = 0; bus.addr = 0; bus.data_in = 0;
    bus0.req = 0; bus0.RE = 0; bus0.WE = 0; bus0.by = 0; bus0.addr = 0; bus0.data_in = 0;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (bus.ack !== 1'b0) begin n_fail++; $display("FAIL reset ack: got %b, expected 0", bus.ack); end
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b, expected 0", bus.busy); end
    n_chk++; if (bus.fault !== 1'b0) begin n_fail++; $display("FAIL reset fault: got %b, expected 0", bus.fault); end
    n_chk++; if (bus.data_out !== 32'h0) begin n_fail++; $display("FAIL reset data_out: got %h, expected 00000000", bus.data_out); end
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (bus0.busy !== 1'b0 || bus0.ack !== 1'b0) begin n_fail++; $display("FAIL reset dut0 idle: busy %b ack %b, expected 0 0", bus0.busy, bus0.ack); end
  endtask

  task automatic test_word_rw();
    vec_t v[2] = '{
      '{1'b0, 1'b1, BY_W, 32'h010, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0},
      '{1'b1, 1'b0, BY_W, 32'h010, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1}
    };
    exp_t e; int lat; logic [31:0] d; logic f; bit to; bit perr;
    foreach (v[i]) begin
      e = '{v[i].xd, v[i].xf, v[i].xchk};
      sb_q.push_back(e);
      run_txn(v[i].re, v[i].we, v[i].by, v[i].a, v[i].wd, lat, d, f, to, perr);
      e = sb_q.pop_front();
      n_chk++; if (to || lat != 3) begin n_fail++; $display("FAIL word[%0d] latency: got %0d cycles, expected 3", i, lat); end
      n_chk++; if (perr) begin n_fail++; $display("FAIL word[%0d] handshake: busy/ack/hold protocol error got 1, expected 0", i); end
      n_chk++; if (f !== e.fault) begin n_fail++; $display("FAIL word[%0d] fault: got %b, expected %b", i, f, e.fault); end
      if (e.chk) begin
        n_chk++; if (d !== e.data) begin n_fail++; $display("FAIL word[%0d] data: got %h, expected %h", i, d, e.data); end
      end
    end
  endtask

  task automatic test_byte_lanes();
    vec_t v[4] = '{
      '{1'b0, 1'b1, BY_B, 32'h013, 32'h123456AA, 32'h0, 1'b0, 1'b0},
      '{1'b1, 1'b0, BY_W, 32'h010, 32'h0, 32'hAAADBEEF, 1'b0, 1'b1},
      '{1'b1, 1'b0, BY_B, 32'h013, 32'h0, 32'h000000AA, 1'b0, 1'b1},
      '{1'b1, 1'b0, BY_B, 32'h010, 32'h0, 32'h000000EF, 1'b0, 1'b1}
    };
    exp_t e; int lat; logic [31:0] d; logic f; bit to; bit perr;
    foreach (v[i]) begin
      e = '{v[i].xd, v[i].xf, v[i].xchk};
      sb_q.push_back(e);
      run_txn(v[i].re, v[i].we, v[i].by, v[i].a, v[i].wd, lat, d, f, to, perr);
      e = sb_q.pop_front();
      n_chk++; if (to || lat != 3) begin n_fail++; $display("FAIL byte[%0d] latency: got %0d cycles, expected 3", i, lat); end
      n_chk++; if (f !== e.fault) begin n_fail++; $display("FAIL byte[%0d] fault: got %b, expected %b", i, f, e.fault); end
      if (e.chk) begin
        n_chk++; if (d !== e.data) begin n_fail++; $display("FAIL byte[%0d] data: got %h, expected %h", i, d, e.data); end
      end
    end
  endtask

  task automatic test_half_lanes();
    vec_t v[5] = '{
      '{1'b0, 1'b1, BY_W, 32'h020, 32'h89ABCDEF, 32'h0, 1'b0, 1'b0},
      '{1'b0, 1'b1, BY_H, 32'h022, 32'hFFFF1234, 32'h0, 1'b0, 1'b0},
      '{1'b1, 1'b0, BY_H, 32'h022, 32'h0, 32'h00001234, 1'b0, 1'b1},
      '{1'b1, 1'b0, BY_W, 32'h020, 32'h0, 32'h1234CDEF, 1'b0, 1'b1},
      '{1'b1, 1'b0, BY_H, 32'h020, 32'h0, 32'h0000CDEF, 1'b0, 1'b1}
    };
    exp_t e; int lat; logic [31:0] d; logic f; bit to; bit perr;
    foreach (v[i]) begin
      e = '{v[i].xd, v[i].xf, v[i].xchk};
      sb_q.push_back(e);
      run_txn(v[i].re, v[i].we, v[i].by, v[i].a, v[i].wd, lat, d, f, to, perr);
      e = sb_q.pop_front();
      n_chk++; if (to || lat != 3) begin n_fail++; $display("FAIL half[%0d] latency: got %0d cycles, expected 3", i, lat); end
      n_chk++; if (f !== e.fault) begin n_fail++; $display("FAIL half[%0d] fault: got %b, expected %b", i, f, e.fault); end
      if (e.chk) begin
        n_chk++; if (d !== e.data) begin n_fail++; $display("FAIL half[%0d] data: got %h, expected %h", i, d, e.data); end
      end
    end
  endtask

  task automatic test_errors();
    vec_t v[7] = '{
      '{1'b1, 1'b0, BY_W,   32'h00001000, 32'h0, 32'h0, 1'b1, 1'b1},
      '{1'b1, 1'b0, BY_RSV, 32'h010, 32'h0, 32'h0, 1'b1, 1'b1},
      '{1'b1, 1'b1, BY_W,   32'h010, 32'h77777777, 32'h0, 1'b1, 1'b1},
      '{1'b1, 1'b0, BY_W,   32'h010, 32'h0, 32'hAAADBEEF, 1'b0, 1'b1},
      '{1'b0, 1'b1, BY_W,   32'h014, 32'h11111111, 32'h0, 1'b0, 1'b0},
      '{1'b0, 1'b1, BY_W,   32'h015, 32'h0BADF00D, 32'h0, ALN, ALN},
      '{1'b1, 1'b0, BY_W,   32'h014, 32'h0, (ALN ? 32'h11111111 : 32'h0BADF00D), 1'b0, 1'b1}
    };
    exp_t e; int lat; logic [31:0] d; logic f; bit to; bit perr;
    foreach (v[i]) begin
      e = '{v[i].xd, v[i].xf, v[i].xchk};
      sb_q.push_back(e);
      run_txn(v[i].re, v[i].we, v[i].by, v[i].a, v[i].wd, lat, d, f, to, perr);
      e = sb_q.pop_front();
      n_chk++; if (to || lat != 3) begin n_fail++; $display("FAIL err[%0d] latency: got %0d cycles, expected 3", i, lat); end
      n_chk++; if (f !== e.fault) begin n_fail++; $display("FAIL err[%0d] fault: got %b, expected %b", i, f, e.fault); end
      if (e.chk) begin
        n_chk++; if (d !== e.data) begin n_fail++; $display("FAIL err[%0d] data: got %h, expected %h", i, d, e.data); end
      end
    end
    // req with neither RE nor WE must be ignored
    @(negedge clk);
    bus.req = 1'b1; bus.RE = 1'b0; bus.WE = 1'b0; bus.addr = 32'h010;
    @(posedge clk); #1;
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ignore_req busy: got %b, expected 0", bus.busy); end
    bus.req = 1'b0;
  endtask

  task automatic test_reset_mid();
    exp_t e; int lat; logic [31:0] d; logic f; bit to; bit perr; int acks;
    e = '{32'h0, 1'b0, 1'b0};
    sb_q.push_back(e);
    run_txn(1'b0, 1'b1, BY_W, 32'h030, 32'h11223344, lat, d, f, to, perr);
    e = sb_q.pop_front();
    n_chk++; if (to || f !== e.fault) begin n_fail++; $display("FAIL rstmid_init: fault %b timeout %0d, expected fault %b no timeout", f, to, e.fault); end
    @(negedge clk);
    bus.req = 1'b1; bus.RE = 1'b0; bus.WE = 1'b1; bus.by = BY_W;
    bus.addr = 32'h030; bus.data_in = 32'h55555555;
    @(posedge clk); #1;
    bus.req = 1'b0; bus.WE = 1'b0;
    n_chk++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_wait busy: got %b, expected 1", bus.busy); end
    #2 reset_n = 1'b0;
    #1;
    n_chk++; if (bus.busy !== 1'b0 || bus.ack !== 1'b0) begin n_fail++; $display("FAIL rstmid_abort: busy %b ack %b, expected 0 0", bus.busy, bus.ack); end
    acks = 0;
    repeat (4) begin @(posedge clk); #1; if (bus.ack) acks++; end
    @(negedge clk) reset_n = 1'b1;
    repeat (4) begin @(posedge clk); #1; if (bus.ack) acks++; end
    n_chk++; if (acks != 0) begin n_fail++; $display("FAIL rstmid_noack: got %0d acks, expected 0", acks); end
    e = '{32'h11223344, 1'b0, 1'b1};
    sb_q.push_back(e);
    run_txn(1'b1, 1'b0, BY_W, 32'h030, 32'h0, lat, d, f, to, perr);
    e = sb_q.pop_front();
    n_chk++; if (to || d !== e.data) begin n_fail++; $display("FAIL rstmid_read data: got %h, expected %h", d, e.data); end
  endtask

  task automatic test_back_to_back();
    exp_t e; int lat;
    @(negedge clk);
    bus0.req = 1'b1; bus0.WE = 1'b1; bus0.RE = 1'b0; bus0.by = BY_W;
    bus0.addr = 32'h040; bus0.data_in = 32'hCAFEF00D;
    e = '{32'h0, 1'b0, 1'b0};          sb_q.push_back(e);
    e = '{32'hCAFEF00D, 1'b0, 1'b1};   sb_q.push_back(e);
    @(posedge clk); #1;
    e = sb_q.pop_front();
    n_chk++; if (bus0.ack !== 1'b1) begin n_fail++; $display("FAIL b2b first ack: got %b one cycle after accept, expected 1", bus0.ack); end
    n_chk++; if (bus0.fault !== e.fault) begin n_fail++; $display("FAIL b2b first fault: got %b, expected %b", bus0.fault, e.fault); end
    // req stays high; the follow-on is a read of the word just written
    bus0.WE = 1'b0; bus0.RE = 1'b1; bus0.data_in = 32'hFFFFFFFF;
    @(posedge clk); #1;
    n_chk++; if (bus0.ack !== 1'b0 || bus0.busy !== 1'b0) begin n_fail++; $display("FAIL b2b gap: ack %b busy %b, expected 0 0", bus0.ack, bus0.busy); end
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!bus0.ack && lat < 20);
    bus0.req = 1'b0; bus0.RE = 1'b0;
    e = sb_q.pop_front();
    n_chk++; if (!bus0.ack || lat != 1) begin n_fail++; $display("FAIL b2b second latency: got %0d cycles, expected 1", lat); end
    n_chk++; if (bus0.data_out !== e.data) begin n_fail++; $display("FAIL b2b second data: got %h, expected %h", bus0.data_out, e.data); end
    n_chk++; if (bus0.fault !== e.fault) begin n_fail++; $display("FAIL b2b second fault: got %b, expected %b", bus0.fault, e.fault); end
    @(posedge clk); #1;
    n_chk++; if (bus0.ack !== 1'b0 || bus0.busy !== 1'b0) begin n_fail++; $display("FAIL b2b release: ack %b busy %b, expected 0 0", bus0.ack, bus0.busy); end
  endtask

  task automatic test_random();
    exp_t e; int lat; logic [31:0] d; logic f; bit to; bit perr;
    logic re, we; logic [1:0] by; logic [31:0] a, wd;
    for (int i = 0; i < 32; i++) begin
      if (i < 8) begin
        re = 1'b0; we = 1'b1; by = BY_W; a = 32'h100 + 32'(4 * i);
      end else begin
        re = 1'($urandom_range(0, 1));
        we = ~re;
        if ($urandom_range(0, 7) == 0) begin re = 1'b1; we = 1'b1; end
        by = ($urandom_range(0, 9) == 0) ? BY_RSV : 2'($urandom_range(0, 2));
        a  = 32'h100 + 32'($urandom_range(0, 31));
        if ($urandom_range(0, 9) == 0) a[20] = 1'b1;
      end
      wd = $urandom;
      e = model(re, we, by, a, wd);
      sb_q.push_back(e);
      run_txn(re, we, by, a, wd, lat, d, f, to, perr);
      e = sb_q.pop_front();
      n_chk++; if (to || lat != 3) begin n_fail++; $display("FAIL rand[%0d] latency: got %0d cycles, expected 3", i, lat); end
      n_chk++; if (f !== e.fault) begin n_fail++; $display("FAIL rand[%0d] fault a=%h by=%b: got %b, expected %b", i, a, by, f, e.fault); end
      if (e.chk) begin
        n_chk++; if (d !== e.data) begin n_fail++; $display("FAIL rand[%0d] data a=%h by=%b: got %h, expected %h", i, a, by, d, e.data); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_byte_lanes();
    test_half_lanes();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
